fir_out_conditioner: RTL and testbench
======================================

FIR_OUT_CONDITIONER -- requirements
Module: fir_out_conditioner

Interface
REQ-001 SHALL have parameter LAT, default 24: clock cycles from a sample on the FIR input port to its result on the FIR Out_Y port.
REQ-002 SHALL have parameter SHIFT, default 13: arithmetic right shift applied before rounding.
REQ-003 SHALL have parameter DEPTH, default 4: output FIFO depth in entries, a power of 2 and at least 2.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1: high in the cycle a new sample is presented on the FIR input.
REQ-007 SHALL have port fir_y  input  29: signed two's-complement FIR output (Out_Y), registered upstream.
REQ-008 SHALL have port decim  input  4: decimation factor, sampled only on a kept sample; 0 is treated as 1.
REQ-009 SHALL have port out_data  output  16: signed, rounded and saturated result at the FIFO head.
REQ-010 SHALL have port out_valid  output  1: high while the FIFO is non-empty.
REQ-011 SHALL have port out_ready  input  1: consumer accepts out_data when out_valid and out_ready are both high.
REQ-012 SHALL have port level  output  log2(DEPTH)+1: current FIFO occupancy.
REQ-013 SHALL have port sat_flag  output  1: sticky flag, set when any pushed result was saturated.
REQ-014 SHALL have port ovf_flag  output  1: sticky flag, set when a result was dropped because the FIFO was full.

Function
REQ-015 SHALL delay in_valid through a LAT-stage shift register; aligned valid (av) SHALL be high exactly when fir_y carries that sample's result.
REQ-016 SHALL compute r = (fir_y + 2^(SHIFT-1)) >>> SHIFT with a 30-bit signed intermediate, so the add never wraps (round half up).
REQ-017 SHALL saturate r to the range [-32768, 32767]; the saturated value is the result, and a saturation sets sat_flag.
REQ-018 SHALL keep a decimation counter dc: on av, a sample is kept when dc==0; then dc loads max(decim,1)-1, otherwise dc decrements.
REQ-019 SHALL not change dc or push anything in cycles where av is low.
REQ-020 SHALL register the kept result in one pipeline stage (stage valid plus 16-bit data); the FIFO push occurs in the following cycle.
REQ-021 SHALL make end-to-end latency from in_valid to out_valid, on an empty FIFO, equal LAT+2 cycles.
REQ-022 SHALL implement the FIFO as first-word-fall-through: out_data shows the head entry, and out_data is don't-care while out_valid is low.
REQ-023 SHALL pop the head on out_valid and out_ready; out_ready while empty SHALL have no effect.
REQ-024 SHALL handle a push while full without a pop by dropping the entry and setting ovf_flag; FIFO contents and level SHALL be unchanged.
REQ-025 SHALL accept a push while full with a simultaneous pop; level SHALL stay DEPTH and ovf_flag SHALL not be set.
REQ-026 SHALL keep level unchanged on a simultaneous push and pop at any level other than empty.
REQ-027 SHALL, on a push while empty with out_ready high, make the entry visible the next cycle; there is no same-cycle bypass.
REQ-028 SHALL wrap the read and write pointers modulo DEPTH.
REQ-029 SHALL clear sat_flag and ovf_flag only by rst.

Reset
REQ-030 SHALL, on rst assertion, immediately clear the valid delay line, dc, the pipeline stage valid, the FIFO pointers, level, sat_flag and ovf_flag.
REQ-031 SHALL hold out_valid=0, out_data=0, level=0, sat_flag=0 and ovf_flag=0 during rst.
REQ-032 SHALL discard all samples in flight when rst is asserted mid-stream; no stale sample SHALL emerge after release.
REQ-033 SHALL make the first in_valid after rst release a kept sample (dc=0).

Verification
REQ-034 SHALL cover rounding: decim=1, single av with fir_y=4096 -> out_data=1; fir_y=-4096 -> 0; fir_y=8192 -> 1; fir_y=-12289 -> -2.
REQ-035 SHALL cover saturation: fir_y=2^28-1 -> out_data=32767 and sat_flag=1; fir_y=-2^28 -> -32768 with no saturation.
REQ-036 SHALL cover latency: in_valid pulse at cycle 0 on an empty FIFO -> out_valid rises at cycle LAT+2=26.
REQ-037 SHALL cover decimation: decim=3 with 9 consecutive valid samples -> samples 0, 3 and 6 kept; decim=0 -> all kept.
REQ-038 SHALL cover overflow: out_ready=0 with 5 kept samples -> level=4, ovf_flag=1, first 4 retained in order; then a push coinciding with a pop at full -> accepted, ovf_flag unchanged.
REQ-039 SHALL cover reset mid-stream: rst for 1 cycle while 3 samples are in the delay line and 2 are in the FIFO -> out_valid=0 and level=0 immediately, and no output until new input.

Source files
------------

// File: rtl/fir_out_conditioner.sv
// fir_out_conditioner: aligns FIR Out_Y with its sample, rounds, saturates,
// decimates and buffers the 16-bit result in a first-word-fall-through FIFO.
module fir_out_conditioner #(
  parameter int LAT   = 24,
  parameter int SHIFT = 13,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic signed [28:0] fir_y,
  input  logic [3:0]         decim,
  output logic signed [15:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [AW:0]        level,
  output logic               sat_flag,
  output logic               ovf_flag
);

  localparam logic signed [29:0] RND  = 30'sd1 <<< (SHIFT - 1);
  localparam logic [AW:0]        FULL = (AW + 1)'(DEPTH);

  logic [LAT-1:0]      vd_q, vd_d;
  logic                av, keep;
  logic [3:0]          dc_q, dc_d;
  logic signed [29:0]  sum, shr;
  logic signed [15:0]  sat_v;
  logic                is_sat;
  logic                st_v_q, st_v_d;
  logic                st_s_q, st_s_d;
  logic signed [15:0]  st_d_q, st_d_d;
  logic signed [15:0]  mem_q [DEPTH];
  logic [AW-1:0]       wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]         lvl_q, lvl_d;
  logic                sat_q, sat_d, ovf_q, ovf_d;
  logic                full, pop, wr, drop;

  assign av        = vd_q[LAT-1];
  assign out_valid = (lvl_q != '0);
  assign out_data  = out_valid ? mem_q[rp_q] : '0;
  assign level     = lvl_q;
  assign sat_flag  = sat_q;
  assign ovf_flag  = ovf_q;

  // Round half up on a 30-bit intermediate, then clamp to 16 bits.
  always_comb begin
    sum    = $signed({fir_y[28], fir_y}) + RND;
    shr    = sum >>> SHIFT;
    sat_v  = shr[15:0];
    is_sat = 1'b0;
    if (shr > 30'sd32767) begin
      sat_v  = 16'sh7FFF;
      is_sat = 1'b1;
    end else if (shr < -30'sd32768) begin
      sat_v  = 16'sh8000;
      is_sat = 1'b1;
    end
  end

  // Next state: valid delay line, decimator, result stage and FIFO control.
  always_comb begin
    vd_d[0] = in_valid;
    for (int i = 1; i < LAT; i++) vd_d[i] = vd_q[i-1];

    keep = av && (dc_q == 4'd0);
    dc_d = dc_q;
    if (av) begin
      if (keep) dc_d = (decim == 4'd0) ? 4'd0 : decim - 4'd1;
      else      dc_d = dc_q - 4'd1;
    end

    st_v_d = keep;
    st_d_d = st_d_q;
    st_s_d = st_s_q;
    if (keep) begin
      st_d_d = sat_v;
      st_s_d = is_sat;
    end

    full = (lvl_q == FULL);
    pop  = out_valid && out_ready;
    wr   = st_v_q && (!full || pop);
    drop = st_v_q && full && !pop;

    wp_d  = wr  ? wp_q + AW'(1) : wp_q;
    rp_d  = pop ? rp_q + AW'(1) : rp_q;
    lvl_d = lvl_q;
    if (wr && !pop)      lvl_d = lvl_q + (AW + 1)'(1);
    else if (!wr && pop) lvl_d = lvl_q - (AW + 1)'(1);

    sat_d = sat_q | (st_v_q & st_s_q);
    ovf_d = ovf_q | drop;
  end

  // Control state; reset discards every sample still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vd_q   <= '0;
      dc_q   <= '0;
      st_v_q <= 1'b0;
      st_s_q <= 1'b0;
      st_d_q <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      lvl_q  <= '0;
      sat_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      vd_q   <= vd_d;
      dc_q   <= dc_d;
      st_v_q <= st_v_d;
      st_s_q <= st_s_d;
      st_d_q <= st_d_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      lvl_q  <= lvl_d;
      sat_q  <= sat_d;
      ovf_q  <= ovf_d;
    end
  end

  // FIFO storage; contents are only meaningful below the level count.
  always_ff @(posedge clk) begin
    if (wr) mem_q[wp_q] <= st_d_q;
  end

endmodule

// File: tb/tb_fir_out_conditioner.sv
// tb_fir_out_conditioner: directed corner cases plus random traffic,
// checked against a queue-based transaction model.
module tb_fir_out_conditioner;

  localparam int LAT   = 24;
  localparam int SHIFT = 13;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic signed [28:0] fir_y;
  logic [3:0]         decim;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic [LW-1:0]      level;
  logic               sat_flag;
  logic               ovf_flag;

  fir_out_conditioner #(
    .LAT(LAT), .SHIFT(SHIFT), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .fir_y(fir_y), .decim(decim), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .sat_flag(sat_flag), .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int c;
    int d;
    bit s;
  } pend_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          due_av[$];
  logic [28:0] yq[$];
  pend_t       pend[$];
  int          mq[$];
  int          m_dc;
  bit          m_sat, m_ovf;

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int mround(input logic signed [28:0] y, output bit s);
    longint t;
    t = longint'(y) + (longint'(1) << (SHIFT - 1));
    t = t >>> SHIFT;
    s = 1'b0;
    if (t > 32767) begin
      t = 32767;
      s = 1'b1;
    end else if (t < -32768) begin
      t = -32768;
      s = 1'b1;
    end
    return int'(t);
  endfunction

  function automatic logic [28:0] rand_y();
    case ($urandom_range(0, 3))
      0:       return 29'($urandom);
      1:       return 29'($urandom_range(0, 65535)) - 29'd32768;
      2:       return 29'h0FFF_FFFF - 29'($urandom_range(0, 20000));
      default: return 29'h1000_0000 + 29'($urandom_range(0, 20000));
    endcase
  endfunction

  task automatic check_all();
    chk("valid", out_valid, mq.size() != 0);
    chk("level", level, mq.size());
    if (mq.size() != 0) chk("data", out_data, mq[0]);
    chk("sat", sat_flag, m_sat);
    chk("ovf", ovf_flag, m_ovf);
  endtask

  task automatic drive_cycle(input bit iv, input logic [28:0] yv,
                             input logic [3:0] dv, input bit rdy);
    bit    av, s, pop, push, full;
    int    r;
    pend_t pe;
    av = (due_av.size() != 0) && (due_av[0] == cyc);
    in_valid  = iv;
    decim     = dv;
    out_ready = rdy;
    if (av) begin
      void'(due_av.pop_front());
      fir_y = yq.pop_front();
    end else begin
      fir_y = 29'($urandom);
    end
    if (iv) begin
      due_av.push_back(cyc + LAT);
      yq.push_back(yv);
    end
    if (av) begin
      if (m_dc == 0) begin
        r = mround(fir_y, s);
        pend.push_back('{c: cyc + 1, d: r, s: s});
        m_dc = (dv == 0) ? 0 : int'(dv) - 1;
      end else begin
        m_dc--;
      end
    end
    full = (mq.size() == DEPTH);
    pop  = (mq.size() != 0) && rdy;
    push = (pend.size() != 0) && (pend[0].c == cyc);
    if (pop) void'(mq.pop_front());
    if (push) begin
      pe = pend.pop_front();
      if (pe.s) m_sat = 1'b1;
      if (full && !pop) m_ovf = 1'b1;
      else mq.push_back(pe.d);
    end
    @(posedge clk);
    cyc++;
    #1;
    check_all();
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_ovf", ovf_flag, 0);
    due_av.delete();
    yq.delete();
    pend.delete();
    mq.delete();
    m_dc  = 0;
    m_sat = 1'b0;
    m_ovf = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n, input logic [3:0] dv, input bit rdy);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, dv, rdy);
  endtask

  task automatic one_shot(input logic signed [28:0] y, input int exp,
                          input string tag);
    int st, lat;
    lat = -1;
    st  = cyc;
    drive_cycle(1'b1, y, 4'd1, 1'b0);
    for (int i = 0; i < 40 && lat < 0; i++) begin
      drive_cycle(1'b0, '0, 4'd1, 1'b0);
      if (out_valid) lat = cyc - st;
    end
    chk({tag, "_lat"}, lat, LAT + 2);
    chk(tag, out_data, exp);
    drive_cycle(1'b0, '0, 4'd1, 1'b1);
  endtask

  task automatic smart_cycle(input bit iv, input logic [28:0] yv);
    bit rdy;
    rdy = (pend.size() != 0) && (pend[0].c == cyc) && (mq.size() == DEPTH);
    drive_cycle(iv, yv, 4'd1, rdy);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    decim     = 4'd1;
    fir_y     = '0;
    #1;
    do_reset();

    one_shot(29'sd4096, 1, "rnd_p4096");
    one_shot(-29'sd4096, 0, "rnd_m4096");
    one_shot(29'sd8192, 1, "rnd_p8192");
    one_shot(-29'sd12289, -2, "rnd_m12289");
    one_shot(29'h1000_0000, -32768, "neg_full");
    chk("no_sat", sat_flag, 0);
    one_shot(29'h0FFF_FFFF, 32767, "pos_sat");
    chk("sat_set", sat_flag, 1);

    for (int k = 0; k < 9; k++) drive_cycle(1'b1, 29'(k * 8192), 4'd3, 1'b0);
    idle(LAT + 4, 4'd3, 1'b0);
    chk("dec3_level", level, 3);
    chk("dec3_k0", out_data, 0);
    drive_cycle(1'b0, '0, 4'd3, 1'b1);
    chk("dec3_k3", out_data, 3);
    drive_cycle(1'b0, '0, 4'd3, 1'b1);
    chk("dec3_k6", out_data, 6);
    drive_cycle(1'b0, '0, 4'd3, 1'b1);
    for (int k = 0; k < 4; k++) drive_cycle(1'b1, 29'(k * 8192), 4'd0, 1'b0);
    idle(LAT + 4, 4'd0, 1'b0);
    chk("dec0_level", level, 4);
    idle(6, 4'd0, 1'b1);

    do_reset();
    for (int k = 20; k < 25; k++) smart_cycle(1'b1, 29'(k * 8192));
    for (int i = 0; i < LAT + 4; i++) smart_cycle(1'b0, '0);
    chk("pp_level", level, 4);
    chk("pp_ovf", ovf_flag, 0);
    chk("pp_head", out_data, 21);
    idle(6, 4'd1, 1'b1);

    for (int k = 10; k < 15; k++) drive_cycle(1'b1, 29'(k * 8192), 4'd1, 1'b0);
    idle(LAT + 4, 4'd1, 1'b0);
    chk("ovf_level", level, 4);
    chk("ovf_flag", ovf_flag, 1);
    for (int k = 10; k < 14; k++) begin
      chk("ovf_order", out_data, k);
      drive_cycle(1'b0, '0, 4'd1, 1'b1);
    end
    chk("ovf_empty", out_valid, 0);

    for (int k = 1; k < 3; k++) drive_cycle(1'b1, 29'(k * 8192), 4'd1, 1'b0);
    idle(LAT + 3, 4'd1, 1'b0);
    for (int k = 3; k < 6; k++) drive_cycle(1'b1, 29'(k * 8192), 4'd1, 1'b0);
    idle(2, 4'd1, 1'b0);
    chk("mid_level", level, 2);
    do_reset();
    idle(LAT + 10, 4'd3, 1'b1);
    chk("mid_quiet", out_valid, 0);
    drive_cycle(1'b1, 29'(7 * 8192), 4'd3, 1'b0);
    idle(LAT + 3, 4'd3, 1'b0);
    chk("mid_first_kept", out_data, 7);
    idle(3, 4'd3, 1'b1);

    for (int i = 0; i < 2000; i++) begin
      bit rdy;
      if (i == 1000) do_reset();
      rdy = ((i % 400) < 200) ? ($urandom_range(0, 3) == 0)
                              : ($urandom_range(0, 4) != 0);
      drive_cycle(1'($urandom_range(0, 1)), rand_y(),
                  4'($urandom_range(0, 4)), rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
